// File: rtl/test_harness_pkg.sv
// Shared types for the riscv-tests run controller: FSM state encoding,
// the tohost pass value and the tohost word decoder.
package test_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_e;

    // Decoder works on a fixed 64-bit view; callers zero-extend narrower
    // write data and keep only the low DATA_W-1 bits of the code.
    localparam int TOHOST_W = 64;
    localparam logic [TOHOST_W-1:0] TOHOST_PASS = 64'd1;

    typedef struct packed {
        logic                  terminate;
        logic                  pass;
        logic [TOHOST_W-2:0]   code;
    } tohost_dec_t;

    // Odd values end the test: 1 is pass, anything else carries the failing
    // test number in the upper bits. Even values are proxy traffic.
    function automatic tohost_dec_t decode_tohost(input logic [TOHOST_W-1:0] data);
        tohost_dec_t r;
        r.terminate = data[0];
        r.pass      = (data == TOHOST_PASS);
        r.code      = r.pass ? '0 : data[TOHOST_W-1:1];
        return r;
    endfunction

endpackage

// File: rtl/test_harness_ctrl_if.sv
// Core data-memory write bus as seen by the run controller.
interface test_harness_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/test_harness_ctrl_tohost_decoder.sv
// tohost snoop: matches the full write address and latches the pass/fail
// verdict and failing test number. `term` is combinational so the owning
// FSM can leave RUN on the same edge the verdict is captured.
module tohost_decoder
    import test_harness_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              term,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W-2:0] code
);
    tohost_dec_t       dec;
    logic              pass_d, pass_q;
    logic              fail_d, fail_q;
    logic [DATA_W-2:0] code_d, code_q;

    // Decode the write and decide the next verdict.
    always_comb begin
        dec    = decode_tohost(TOHOST_W'(wdata));
        term   = en && we && (addr == TOHOST_ADDR) && dec.terminate;
        pass_d = pass_q;
        fail_d = fail_q;
        code_d = code_q;
        if (clr) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
            code_d = '0;
        end else if (term) begin
            pass_d = dec.pass;
            fail_d = !dec.pass;
            code_d = dec.code[DATA_W-2:0];
        end
    end

    // Verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= '0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            code_q <= code_d;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
    assign code = code_q;
endmodule

// File: rtl/test_harness_ctrl.sv
// Run controller for riscv-tests images: sequences Core reset, counts RUN
// cycles, enforces a watchdog and reports the tohost verdict.
// Optional stall detector: define TEST_HARNESS_STALL_DETECT_EN.
module test_harness_ctrl
    import test_harness_pkg::*;
#(
    parameter int                RST_CYCLES  = 2,
    parameter int                TIMEOUT     = 5000,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int                CNT_W       = 32
`ifdef TEST_HARNESS_STALL_DETECT_EN
    ,
    parameter int                STALL_CYCLES = 64
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                core_rst,
    test_harness_ctrl_if.slave  mem,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [DATA_W-2:0]   fail_code,
    output logic [CNT_W-1:0]    cycle_count
`ifdef TEST_HARNESS_STALL_DETECT_EN
    ,
    input  logic                pc_valid,
    input  logic [ADDR_W-1:0]   pc,
    output logic                stall
`endif
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e           state_d, state_q;
    logic [RC_W-1:0]  rst_cnt_d, rst_cnt_q;
    logic [CNT_W-1:0] cyc_d, cyc_q;
    logic             done_d, done_q;
    logic             tmo_d, tmo_q;
    logic             dec_clr, dec_en, term;
`ifdef TEST_HARNESS_STALL_DETECT_EN
    localparam int SC_W = $clog2(STALL_CYCLES + 1);
    logic [SC_W-1:0]   stall_cnt_d, stall_cnt_q;
    logic [ADDR_W-1:0] last_pc_d, last_pc_q;
    logic              last_vld_d, last_vld_q;
    logic              stall_d, stall_q;
    logic              pc_same, stall_hit;
`endif

    tohost_decoder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TOHOST_ADDR (TOHOST_ADDR)
    ) u_dec (
        .clk   (clk),
        .rst   (rst),
        .clr   (dec_clr),
        .en    (dec_en),
        .we    (mem.we),
        .addr  (mem.addr),
        .wdata (mem.wdata),
        .term  (term),
        .pass  (pass),
        .fail  (fail),
        .code  (fail_code)
    );

    // Next-state, counters and flags; priority in RUN is tohost > stall > timeout.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        dec_clr   = 1'b0;
        dec_en    = 1'b0;
`ifdef TEST_HARNESS_STALL_DETECT_EN
        stall_cnt_d = stall_cnt_q;
        last_pc_d   = last_pc_q;
        last_vld_d  = last_vld_q;
        stall_d     = stall_q;
        pc_same     = pc_valid && last_vld_q && (pc == last_pc_q);
        stall_hit   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RC_W'(RST_CYCLES - 1);
                    cyc_d     = '0;
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    dec_clr   = 1'b1;
`ifdef TEST_HARNESS_STALL_DETECT_EN
                    stall_cnt_d = '0;
                    last_vld_d  = 1'b0;
                    stall_d     = 1'b0;
`endif
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == '0) state_d = ST_RUN;
                else                 rst_cnt_d = rst_cnt_q - 1'b1;
            end
            ST_RUN: begin
                dec_en = 1'b1;
                cyc_d  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
`ifdef TEST_HARNESS_STALL_DETECT_EN
                // A differing valid pc restarts the run length; an invalid
                // cycle leaves both the count and the latched pc alone.
                if (pc_valid) begin
                    last_pc_d   = pc;
                    last_vld_d  = 1'b1;
                    stall_cnt_d = pc_same ? stall_cnt_q + 1'b1 : '0;
                end
                stall_hit = pc_same && (stall_cnt_q == SC_W'(STALL_CYCLES - 1));
`endif
                if (term) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
`ifdef TEST_HARNESS_STALL_DETECT_EN
                end else if (stall_hit) begin
                    stall_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
`endif
                end else if (cyc_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
`ifdef TEST_HARNESS_STALL_DETECT_EN
            stall_cnt_q <= '0;
            last_pc_q   <= '0;
            last_vld_q  <= 1'b0;
            stall_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
`ifdef TEST_HARNESS_STALL_DETECT_EN
            stall_cnt_q <= stall_cnt_d;
            last_pc_q   <= last_pc_d;
            last_vld_q  <= last_vld_d;
            stall_q     <= stall_d;
`endif
        end
    end

    // Core only runs in RUN; it is frozen in DONE and held while idle.
    assign core_rst    = (state_q != ST_RUN);
    assign done        = done_q;
    assign timeout     = tmo_q;
    assign cycle_count = cyc_q;
`ifdef TEST_HARNESS_STALL_DETECT_EN
    assign stall       = stall_q;
`endif
endmodule

// File: tb/tb_test_harness_ctrl.sv
// Directed bench for test_harness_ctrl (RST_CYCLES=2, TIMEOUT=120).
// Inputs change and outputs are checked on the falling clock edge.
module tb_test_harness_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              core_rst, done, pass, fail, timeout;
    logic [DATA_W-2:0] fail_code;
    logic [CNT_W-1:0]  cycle_count;
`ifdef TEST_HARNESS_STALL_DETECT_EN
    logic              pc_valid;
    logic [ADDR_W-1:0] pc;
    logic              stall;
`endif

    int n_checks = 0;
    int n_err    = 0;

    test_harness_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    test_harness_ctrl #(
        .RST_CYCLES  (2),
        .TIMEOUT     (120),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TOHOST_ADDR (32'h0000_1000),
        .CNT_W       (CNT_W)
`ifdef TEST_HARNESS_STALL_DETECT_EN
        ,
        .STALL_CYCLES (8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core_rst    (core_rst),
        .mem         (mem_if.slave),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
`ifdef TEST_HARNESS_STALL_DETECT_EN
        ,
        .pc_valid    (pc_valid),
        .pc          (pc),
        .stall       (stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One write beat to the core data-memory bus.
    task automatic mem_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_if.we    = 1'b1;
        mem_if.addr  = a;
        mem_if.wdata = d;
        tick();
        mem_if.we    = 1'b0;
    endtask

    // Start pulse, then core_rst must stay high for exactly two cycles.
    // hit_in_reset drives a passing tohost write for the whole RESET window.
    task automatic run_start(input bit hit_in_reset);
        start = 1'b1;
        if (hit_in_reset) begin
            mem_if.we    = 1'b1;
            mem_if.addr  = 32'h1000;
            mem_if.wdata = 32'h1;
        end
        tick();
        start = 1'b0;
        check("rst_c1", core_rst, 1);
        check("clr_done", done, 0);
        tick();
        check("rst_c2", core_rst, 1);
        tick();
        mem_if.we = 1'b0;
        check("run_core_rst", core_rst, 0);
        check("run_cnt0", cycle_count, 0);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        mem_if.we    = 1'b0;
        mem_if.addr  = '0;
        mem_if.wdata = '0;
`ifdef TEST_HARNESS_STALL_DETECT_EN
        pc_valid = 1'b0;
        pc       = '0;
`endif
        tick();
        tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_done", done, 0);
        check("rst_flags", {pass, fail, timeout}, 0);
        check("rst_code", fail_code, 0);
        check("rst_cnt", cycle_count, 0);
        rst = 1'b0;
        tick();
        check("idle_core_rst", core_rst, 1);

        // pass at run cycle 100
        run_start(1'b0);
        repeat (100) tick();
        check("pre_pass_cnt", cycle_count, 100);
        mem_wr(32'h1000, 32'h1);
        check("pass_done", done, 1);
        check("pass_flag", pass, 1);
        check("pass_fail", fail, 0);
        check("pass_tmo", timeout, 0);
        check("pass_cnt", cycle_count, 101);
        check("pass_core_rst", core_rst, 1);
        tick();
        tick();
        check("hold_cnt", cycle_count, 101);
        check("hold_pass", {done, pass}, 2'b11);

        // fail with test number 3
        run_start(1'b0);
        check("rerun_pass_clr", pass, 0);
        repeat (10) tick();
        mem_wr(32'h1000, 32'h7);
        check("fail_flag", fail, 1);
        check("fail_code", fail_code, 3);
        check("fail_pass", pass, 0);
        check("fail_done", done, 1);
        check("fail_cnt", cycle_count, 11);

        // even values and wrong address ignored, then watchdog
        run_start(1'b0);
        mem_wr(32'h1000, 32'h0);
        mem_wr(32'h1000, 32'h4);
        mem_wr(32'h1004, 32'h1);
        check("ign_done", done, 0);
        check("ign_cnt", cycle_count, 3);
        n = 3;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check("tmo_wait", done, 1);
        check("tmo_cycles", n, 120);
        check("tmo_flag", timeout, 1);
        check("tmo_pf", {pass, fail}, 0);
        check("tmo_cnt", cycle_count, 120);

        // hit on the timeout cycle wins
        run_start(1'b0);
        repeat (119) tick();
        mem_wr(32'h1000, 32'h1);
        check("race_pass", pass, 1);
        check("race_tmo", timeout, 0);
        check("race_done", done, 1);

        // RESET ignores writes, RUN ignores start, rst mid-run
        run_start(1'b1);
        repeat (20) tick();
        check("rsthit_ign", done, 0);
        check("rsthit_cnt", cycle_count, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ign", core_rst, 0);
        check("run_start_cnt", cycle_count, 21);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_core", core_rst, 1);
        check("mid_rst_flags", {done, pass, fail, timeout}, 0);
        check("mid_rst_cnt", cycle_count, 0);
        tick();
        check("mid_rst_idle", {core_rst, cycle_count}, {1'b1, 32'd0});

`ifdef TEST_HARNESS_STALL_DETECT_EN
        // first RUN cycle latches pc, then 8 repeats trip the detector
        run_start(1'b0);
        pc_valid = 1'b1;
        pc       = 32'h80;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("stall_wait", done, 1);
        check("stall_cycles", n, 9);
        check("stall_flag", stall, 1);
        check("stall_others", {pass, fail, timeout}, 0);
        pc_valid = 1'b0;
        run_start(1'b0);
        check("stall_clr", stall, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
